// File: rtl/node_store.sv
// Ordered (X,Y) node table: loads pairs until finish_init, then freezes for the pathfinding core.
// Optional duplicate suppression is enabled by defining NODE_STORE_DEDUP_EN.
module node_store #(
    parameter int COORD_W = 16,
    parameter int DEPTH   = 16,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    output logic               in_ready,
    input  logic               finish_init,
    input  logic               clear,
    input  logic [AW-1:0]      rd_addr,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y,
    output logic               rd_oob,
    output logic [CW-1:0]      node_count,
    output logic               full,
    output logic               overflow,
    output logic               done
`ifdef NODE_STORE_DEDUP_EN
    ,
    output logic               dup_seen
`endif
);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [CW-1:0]      count_r;
    logic [CW-1:0]      next_count_s;
    logic               full_s;
    logic               accept_s;
    logic               store_s;
    logic               ovf_set_s;
    logic               dup_s;
    logic               in_ready_r;
    logic               full_r;
    logic               overflow_r;
    logic               done_r;
    logic [COORD_W-1:0] rd_x_r;
    logic [COORD_W-1:0] rd_y_r;
    logic               rd_oob_r;
    logic [COORD_W-1:0] mem_x_r [DEPTH];
    logic [COORD_W-1:0] mem_y_r [DEPTH];

    assign full_s = (count_r == CW'(DEPTH));

`ifdef NODE_STORE_DEDUP_EN
    logic dup_seen_r;

    // Match the offered pair against every valid stored entry.
    always_comb begin
        dup_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            dup_s = dup_s | ((CW'(i) < count_r) && (mem_x_r[i] == in_x) && (mem_y_r[i] == in_y));
        end
    end

    // Sticky duplicate flag, cleared together with the table.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dup_seen_r <= 1'b0;
        end else if (clear) begin
            dup_seen_r <= 1'b0;
        end else if (accept_s && dup_s) begin
            dup_seen_r <= 1'b1;
        end
    end

    assign dup_seen = dup_seen_r;
`else
    assign dup_s = 1'b0;
`endif

    // Next-state, handshake and count decode; clear overrides everything.
    always_comb begin
        next_state_s = state_r;
        next_count_s = count_r;
        accept_s     = 1'b0;
        ovf_set_s    = 1'b0;
        if (state_r == ST_LOAD && in_valid) begin
            if (full_s) begin
                ovf_set_s = 1'b1;
            end else begin
                accept_s = 1'b1;
            end
        end else begin
            accept_s = 1'b0;
        end
        store_s = accept_s & ~dup_s;
        if (store_s) begin
            next_count_s = count_r + CW'(1);
        end else begin
            next_count_s = count_r;
        end
        case (state_r)
            ST_LOAD: next_state_s = finish_init ? ST_DONE : ST_LOAD;
            ST_DONE: next_state_s = ST_DONE;
            default: next_state_s = ST_LOAD;
        endcase
        if (clear) begin
            next_state_s = ST_LOAD;
            next_count_s = '0;
            store_s      = 1'b0;
            ovf_set_s    = 1'b0;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // Control state and status outputs, all registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_LOAD;
            count_r    <= '0;
            in_ready_r <= 1'b1;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            count_r    <= next_count_s;
            in_ready_r <= (next_state_s == ST_LOAD) && (next_count_s != CW'(DEPTH));
            full_r     <= (next_count_s == CW'(DEPTH));
            overflow_r <= clear ? 1'b0 : (overflow_r | ovf_set_s);
            done_r     <= (next_state_s == ST_DONE);
        end
    end

    // Table write; contents are not reset, validity is tracked by count_r.
    always_ff @(posedge clk) begin
        if (reset && store_s) begin
            mem_x_r[count_r[AW-1:0]] <= in_x;
            mem_y_r[count_r[AW-1:0]] <= in_y;
        end
    end

    // Registered read port; out-of-range indices return zero coordinates.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_x_r   <= '0;
            rd_y_r   <= '0;
            rd_oob_r <= 1'b1;
        end else if ({1'b0, rd_addr} >= count_r) begin
            rd_x_r   <= '0;
            rd_y_r   <= '0;
            rd_oob_r <= 1'b1;
        end else begin
            rd_x_r   <= mem_x_r[rd_addr];
            rd_y_r   <= mem_y_r[rd_addr];
            rd_oob_r <= 1'b0;
        end
    end

    assign in_ready   = in_ready_r;
    assign full       = full_r;
    assign overflow   = overflow_r;
    assign done       = done_r;
    assign node_count = count_r;
    assign rd_x       = rd_x_r;
    assign rd_y       = rd_y_r;
    assign rd_oob     = rd_oob_r;

endmodule

// File: tb/tb_node_store.sv
// Directed bench for node_store: a cycle-by-cycle vector table plus hand-written corner sequences.
module tb_node_store;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_x;
    logic [15:0] in_y;
    logic        in_ready;
    logic        finish_init;
    logic        clear;
    logic [3:0]  rd_addr;
    logic [15:0] rd_x;
    logic [15:0] rd_y;
    logic        rd_oob;
    logic [4:0]  node_count;
    logic        full;
    logic        overflow;
    logic        done;
`ifdef NODE_STORE_DEDUP_EN
    logic        dup_seen;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    node_store #(.COORD_W(16), .DEPTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_ready   (in_ready),
        .finish_init(finish_init),
        .clear      (clear),
        .rd_addr    (rd_addr),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_oob     (rd_oob),
        .node_count (node_count),
        .full       (full),
        .overflow   (overflow),
        .done       (done)
`ifdef NODE_STORE_DEDUP_EN
        ,
        .dup_seen   (dup_seen)
`endif
    );

    typedef struct {
        logic        v;
        logic [15:0] x;
        logic [15:0] y;
        logic        fin;
        logic        clr;
        logic [3:0]  ra;
        logic [4:0]  e_cnt;
        logic        e_done;
        logic        e_rdy;
        logic        e_full;
        logic        e_ovf;
        logic        e_oob;
        logic [15:0] e_x;
        logic [15:0] e_y;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic v, input logic [15:0] x, input logic [15:0] y,
                        input logic fin, input logic clr, input logic [3:0] ra);
        in_valid    = v;
        in_x        = x;
        in_y        = y;
        finish_init = fin;
        clear       = clr;
        rd_addr     = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic v, input logic [15:0] x, input logic [15:0] y, input logic fin,
                       input logic clr, input logic [3:0] ra, input logic [4:0] cnt, input logic dn,
                       input logic rdy, input logic fl, input logic ovf, input logic oob,
                       input logic [15:0] ex, input logic [15:0] ey);
        vec_t t;
        t = '{v, x, y, fin, clr, ra, cnt, dn, rdy, fl, ovf, oob, ex, ey};
        vecs.push_back(t);
    endtask

    initial begin
        reset = 1'b0;
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 4'd0);
        step(1'b1, 16'd77, 16'd77, 1'b0, 1'b0, 4'd0);
        check("rst_cnt", 0, 32'(node_count), 32'd0);
        check("rst_done", 0, 32'(done), 32'd0);
        check("rst_rdy", 0, 32'(in_ready), 32'd1);
        check("rst_ovf", 0, 32'(overflow), 32'd0);
        check("rst_oob", 0, 32'(rd_oob), 32'd1);
        check("rst_rdx", 0, 32'(rd_x), 32'd0);
        check("rst_rdy_coord", 0, 32'(rd_y), 32'd0);
        reset = 1'b1;

        //   v     x       y       fin   clr   ra    cnt   done  rdy   full  ovf   oob   ex      ey
        add(1'b1, 16'd3, 16'd5, 1'b0, 1'b0, 4'd0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0);
        add(1'b1, 16'd7, 16'd2, 1'b0, 1'b0, 4'd0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 16'd5);
        add(1'b1, 16'd9, 16'd9, 1'b0, 1'b0, 4'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0);
        add(1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 4'd1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd7, 16'd2);
        add(1'b1, 16'd1, 16'd1, 1'b1, 1'b0, 4'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd9, 16'd9);
        add(1'b1, 16'd4, 16'd4, 1'b0, 1'b1, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 16'd5);
        add(1'b1, 16'd4, 16'd4, 1'b1, 1'b0, 4'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0);
        add(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 4'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 16'd4);
        add(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 4'd3, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0);
        add(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd4, 16'd4);
        add(1'b1, 16'd5, 16'd6, 1'b0, 1'b0, 4'd1, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0);
        add(1'b1, 16'd8, 16'd1, 1'b0, 1'b0, 4'd3, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0);
        add(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 4'd3, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0);
        add(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 4'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd8, 16'd1);

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].x, vecs[i].y, vecs[i].fin, vecs[i].clr, vecs[i].ra);
            check("vec_cnt", i, 32'(node_count), 32'(vecs[i].e_cnt));
            check("vec_done", i, 32'(done), 32'(vecs[i].e_done));
            check("vec_ready", i, 32'(in_ready), 32'(vecs[i].e_rdy));
            check("vec_full", i, 32'(full), 32'(vecs[i].e_full));
            check("vec_ovf", i, 32'(overflow), 32'(vecs[i].e_ovf));
            check("vec_oob", i, 32'(rd_oob), 32'(vecs[i].e_oob));
            check("vec_rdx", i, 32'(rd_x), 32'(vecs[i].e_x));
            check("vec_rdy", i, 32'(rd_y), 32'(vecs[i].e_y));
        end

        // Clear in DONE with five nodes, while a pair is offered.
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 16'(10 + i), 16'(20 + i), 1'b0, 1'b0, 4'd0);
        step(1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 4'd4);
        check("a_cnt5", 0, 32'(node_count), 32'd5);
        check("a_done", 0, 32'(done), 32'd1);
        step(1'b1, 16'd50, 16'd50, 1'b0, 1'b1, 4'd4);
        check("a_rd4", 0, 32'(rd_x), 32'd14);
        check("a_clr_cnt", 0, 32'(node_count), 32'd0);
        check("a_clr_done", 0, 32'(done), 32'd0);
        check("a_clr_ovf", 0, 32'(overflow), 32'd0);
        check("a_clr_rdy", 0, 32'(in_ready), 32'd1);
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 4'd0);
        check("a_after_cnt", 0, 32'(node_count), 32'd0);
        check("a_after_oob", 0, 32'(rd_oob), 32'd1);

        // Fill to DEPTH, then offer one more.
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 16'(i), 16'(i + 100), 1'b0, 1'b0, 4'd0);
            check("b_cnt", i, 32'(node_count), 32'(i + 1));
        end
        check("b_full", 0, 32'(full), 32'd1);
        check("b_rdy", 0, 32'(in_ready), 32'd0);
        check("b_ovf_pre", 0, 32'(overflow), 32'd0);
        step(1'b1, 16'd99, 16'd99, 1'b0, 1'b0, 4'd15);
        check("b_ovf", 0, 32'(overflow), 32'd1);
        check("b_cnt_hold", 0, 32'(node_count), 32'd16);
        check("b_rd15x", 0, 32'(rd_x), 32'd15);
        check("b_rd15y", 0, 32'(rd_y), 32'd115);
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 4'd0);
        check("b_ovf_sticky", 0, 32'(overflow), 32'd1);
        check("b_cnt_hold2", 0, 32'(node_count), 32'd16);
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 4'd0);
        check("b_clr_ovf", 0, 32'(overflow), 32'd0);
        check("b_clr_full", 0, 32'(full), 32'd0);
        check("b_clr_cnt", 0, 32'(node_count), 32'd0);

        // Reset mid-load with a pair offered in the reset cycle.
        step(1'b1, 16'd30, 16'd31, 1'b0, 1'b0, 4'd0);
        step(1'b1, 16'd32, 16'd33, 1'b0, 1'b0, 4'd0);
        reset = 1'b0;
        step(1'b1, 16'd34, 16'd35, 1'b0, 1'b0, 4'd0);
        check("c_rst_cnt", 0, 32'(node_count), 32'd0);
        check("c_rst_oob", 0, 32'(rd_oob), 32'd1);
        check("c_rst_rdx", 0, 32'(rd_x), 32'd0);
        reset = 1'b1;
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 4'd0);
        check("c_post_cnt", 0, 32'(node_count), 32'd0);
        check("c_post_oob", 0, 32'(rd_oob), 32'd1);

        // Duplicate handling.
        step(1'b1, 16'd1, 16'd2, 1'b0, 1'b0, 4'd0);
        step(1'b1, 16'd1, 16'd2, 1'b0, 1'b0, 4'd0);
        step(1'b1, 16'd2, 16'd1, 1'b0, 1'b0, 4'd0);
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 4'd1);
`ifdef NODE_STORE_DEDUP_EN
        check("d_cnt", 0, 32'(node_count), 32'd2);
        check("d_dup", 0, 32'(dup_seen), 32'd1);
        check("d_rd1x", 0, 32'(rd_x), 32'd2);
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 4'd0);
        check("d_dup_clr", 0, 32'(dup_seen), 32'd0);
`else
        check("d_cnt", 0, 32'(node_count), 32'd3);
        check("d_rd1x", 0, 32'(rd_x), 32'd1);
        check("d_rd1y", 0, 32'(rd_y), 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
